// File: rtl/adc_rr_scheduler.sv
// Round-robin scheduler that shares one 8-bit ADC among 4 consumers and delivers tagged samples.
// Request to soc is 2 clocks and eoc to dav_ is 2 clocks; consumers may stall DAV indefinitely, and a watchdog aborts stuck conversions.
module adc_rr_scheduler #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  output logic       soc,
  input  logic       eoc,
  output logic [1:0] sel,
  input  logic [7:0] x,
  output logic [7:0] data,
  output logic [1:0] ch,
  output logic       dav_,
  input  logic       rfd,
  output logic       err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DAV,
    S_ACK,
    S_ABORT
  } state_t;

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  sel_q, sel_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        soc_q, soc_d;
  logic        dav_n_q, dav_n_d;
  logic        err_q, err_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  ch_q, ch_d;

  logic [1:0]  rot_amt;
  logic [7:0]  req_dbl;
  logic [3:0]  req_rot;
  logic [1:0]  pick_ofs;
  logic [1:0]  grant;
  logic [9:0]  cnt_inc;

  // Rotate requests so the channel after last sits at bit 0, then take the lowest set bit.
  always_comb begin
    rot_amt = last_q + 2'd1;
    req_dbl = {req, req};
    req_rot = req_dbl[{1'b0, rot_amt} +: 4];
    casez (req_rot)
      4'b???1: pick_ofs = 2'd0;
      4'b??10: pick_ofs = 2'd1;
      4'b?100: pick_ofs = 2'd2;
      default: pick_ofs = 2'd3;
    endcase
    grant = rot_amt + pick_ofs;
  end

  assign cnt_inc = (cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    soc_d   = soc_q;
    dav_n_d = dav_n_q;
    err_d   = err_q;
    data_d  = data_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: begin
        soc_d = 1'b0;
        err_d = 1'b0;
        if (eoc && (req != 4'b0000)) begin
          sel_d   = grant;
          cnt_d   = 10'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        soc_d = 1'b1;
        cnt_d = cnt_inc;
        if (!eoc) begin
          soc_d   = 1'b0;
          cnt_d   = 10'd0;
          state_d = S_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ABORT;
        end
      end
      S_WAIT: begin
        soc_d = 1'b0;
        cnt_d = cnt_inc;
        if (eoc) begin
          data_d  = x;
          ch_d    = sel_q;
          state_d = S_DAV;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ABORT;
        end
      end
      S_DAV: begin
        dav_n_d = 1'b0;
        if (!rfd) state_d = S_ACK;
      end
      S_ACK: begin
        dav_n_d = 1'b1;
        if (rfd) begin
          last_d  = ch_q;
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        // Failed channel drops to lowest priority, previous sample stays on the bus.
        soc_d   = 1'b0;
        err_d   = 1'b1;
        last_d  = sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      cnt_q   <= 10'd0;
      soc_q   <= 1'b0;
      dav_n_q <= 1'b1;
      err_q   <= 1'b0;
      data_q  <= 8'd0;
      ch_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      soc_q   <= soc_d;
      dav_n_q <= dav_n_d;
      err_q   <= err_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign soc  = soc_q;
  assign sel  = sel_q;
  assign data = data_q;
  assign ch   = ch_q;
  assign dav_ = dav_n_q;
  assign err  = err_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_rr_scheduler.sv
// Bench for adc_rr_scheduler: cycle table, directed corner sequences and randomized
// transactions checked against a transaction-level round-robin/timeout model.
module tb_adc_rr_scheduler;

  localparam int TO = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0;
  logic       soc;
  logic       eoc   = 1'b1;
  logic [1:0] sel;
  logic [7:0] x     = 8'h00;
  logic [7:0] data;
  logic [1:0] ch;
  logic       dav_;
  logic       rfd   = 1'b1;
  logic       err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [1:0] m_last;
  logic [1:0] m_ch;
  logic [7:0] m_data;

  adc_rr_scheduler #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .soc(soc), .eoc(eoc), .sel(sel),
    .x(x), .data(data), .ch(ch), .dav_(dav_), .rfd(rfd), .err(err), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    for (int i = 1; i <= 4; i++) begin
      idx = 2'((int'(last) + i) % 4);
      if (r[idx]) return idx;
    end
    return last;
  endfunction

  task automatic do_reset;
    reset = 1'b1; req = 4'b0; eoc = 1'b1; rfd = 1'b1; x = 8'h00;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    m_last = 2'd3; m_ch = 2'd0; m_data = 8'h00;
  endtask

  // One arbitration + conversion + delivery. a: edges eoc stays high after grant,
  // b: edges eoc stays low in WAIT; either reaching TO means a watchdog abort.
  task automatic txn(input logic [3:0] r, input int pre, input int a, input int b,
                     input logic [7:0] xv, input int rd, input bit early,
                     output logic [1:0] g);
    int n;
    bit done;
    logic [1:0] exp_g;
    exp_g = rr_pick(r, m_last);
    req = r; rfd = 1'b1; x = xv; eoc = 1'b0;
    for (int i = 0; i < pre; i++) begin
      tick;
      chk("idle_conv_busy", {busy, soc}, 2'b00);
    end
    eoc = 1'b1;
    tick;
    g = sel;
    chk("grant", {busy, soc, sel}, {1'b1, 1'b0, exp_g});
    req = 4'($urandom);
    n = 0; done = 1'b0;
    while (!done && n < 40) begin
      n++;
      eoc = (n <= a) ? 1'b1 : (n <= a + 1 + b) ? 1'b0 : 1'b1;
      if (early && n >= a + 2 + b) rfd = 1'b0;
      tick;
      if (n == 1) chk("soc_rise", soc, (a >= 1));
      if (err || !dav_) done = 1'b1;
    end
    if (!done) begin
      chk("txn_timeout", 0, 1);
      do_reset;
      return;
    end
    if (a >= TO || b >= TO) begin
      chk("abort_time", n, (a >= TO) ? TO + 1 : a + TO + 2);
      chk("abort_out", {err, soc, dav_, busy, ch, data}, {4'b1010, m_ch, m_data});
      req = 4'b0; eoc = 1'b1; rfd = 1'b1;
      tick;
      chk("err_pulse", {err, busy}, 2'b00);
    end else begin
      chk("dav_time", n, a + b + 3);
      chk("dav_data", {ch, data}, {exp_g, xv});
      m_ch = exp_g; m_data = xv;
      if (early) begin
        rfd = 1'b0;
        tick;
        chk("dav_one_cycle", {dav_, busy}, 2'b11);
      end else begin
        for (int i = 0; i < rd; i++) begin
          tick;
          chk("dav_hold", dav_, 1'b0);
        end
        rfd = 1'b0;
        tick;
        chk("dav_ack", dav_, 1'b0);
        tick;
        chk("dav_release", {dav_, busy}, 2'b11);
      end
      req = 4'b0; rfd = 1'b1;
      tick;
      chk("back_idle", busy, 1'b0);
    end
    m_last = exp_g;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       eoc;
    logic [7:0] x;
    logic       rfd;
    logic       soc;
    logic       dav_n;
    logic       busy;
    logic       err;
    logic [1:0] sel;
    logic [1:0] ch;
    logic [7:0] data;
  } vec_t;

  initial begin
    vec_t vec[12];
    logic [1:0] g;
    logic [1:0] rr_exp[6];

    // Single conversion on channel 2, req dropped right after the grant.
    vec[0]  = '{4'b0100, 1, 8'h00, 1, 0, 1, 1, 0, 2'd2, 2'd0, 8'h00};
    vec[1]  = '{4'b0000, 1, 8'h00, 1, 1, 1, 1, 0, 2'd2, 2'd0, 8'h00};
    vec[2]  = '{4'b0000, 1, 8'h00, 1, 1, 1, 1, 0, 2'd2, 2'd0, 8'h00};
    vec[3]  = '{4'b0000, 1, 8'h00, 1, 1, 1, 1, 0, 2'd2, 2'd0, 8'h00};
    vec[4]  = '{4'b0000, 0, 8'h00, 1, 0, 1, 1, 0, 2'd2, 2'd0, 8'h00};
    vec[5]  = '{4'b0000, 0, 8'h00, 1, 0, 1, 1, 0, 2'd2, 2'd0, 8'h00};
    vec[6]  = '{4'b0000, 1, 8'hA5, 1, 0, 1, 1, 0, 2'd2, 2'd2, 8'hA5};
    vec[7]  = '{4'b0000, 1, 8'h00, 1, 0, 0, 1, 0, 2'd2, 2'd2, 8'hA5};
    vec[8]  = '{4'b0000, 1, 8'h00, 1, 0, 0, 1, 0, 2'd2, 2'd2, 8'hA5};
    vec[9]  = '{4'b0000, 1, 8'h00, 0, 0, 0, 1, 0, 2'd2, 2'd2, 8'hA5};
    vec[10] = '{4'b0000, 1, 8'h00, 0, 0, 1, 1, 0, 2'd2, 2'd2, 8'hA5};
    vec[11] = '{4'b0000, 1, 8'h00, 1, 0, 1, 0, 0, 2'd2, 2'd2, 8'hA5};
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    do_reset;
    chk("reset_state", {soc, dav_, busy, err, sel, ch, data}, {4'b0100, 2'd0, 2'd0, 8'h00});

    for (int i = 0; i < 12; i++) begin
      req = vec[i].req; eoc = vec[i].eoc; x = vec[i].x; rfd = vec[i].rfd;
      tick;
      chk($sformatf("vec%0d", i), {soc, dav_, busy, err, sel, ch, data},
          {vec[i].soc, vec[i].dav_n, vec[i].busy, vec[i].err, vec[i].sel, vec[i].ch, vec[i].data});
    end

    // Reset in the middle of WAIT on channel 1.
    do_reset;
    req = 4'b0010; eoc = 1'b1; x = 8'h3C;
    tick; tick;
    eoc = 1'b0; req = 4'b0;
    tick; tick;
    chk("pre_reset_wait", {busy, soc, sel}, {2'b10, 2'd1});
    #2 reset = 1'b1;
    #1 chk("reset_async", {soc, dav_, busy, err, sel, ch, data}, {4'b0100, 2'd0, 2'd0, 8'h00});
    #1 reset = 1'b0;
    eoc = 1'b1;
    m_last = 2'd3; m_ch = 2'd0; m_data = 8'h00;
    txn(4'b0001, 0, 2, 1, 8'h5A, 1, 1'b0, g);
    chk("post_reset_grant", g, 2'd0);

    // All four requesting: strict rotation.
    do_reset;
    for (int i = 0; i < 6; i++) begin
      txn(4'b1111, 0, 1, 1, 8'($urandom), 0, 1'b0, g);
      chk($sformatf("rr_order%0d", i), g, rr_exp[i]);
    end

    // Fairness: channel 0 just served, so 3 wins over 0.
    txn(4'b0001, 0, 0, 0, 8'h11, 0, 1'b1, g);
    txn(4'b1001, 0, 3, 2, 8'h22, 2, 1'b0, g);
    chk("fair_first", g, 2'd3);
    txn(4'b1001, 0, 1, 0, 8'h33, 0, 1'b0, g);
    chk("fair_second", g, 2'd0);

    // Watchdog in START (eoc stuck high) and in WAIT, with timeout boundaries.
    txn(4'b0110, 0, 20, 0, 8'h44, 0, 1'b0, g);
    chk("wd_start_grant", g, 2'd1);
    txn(4'b0110, 0, 1, 0, 8'h55, 0, 1'b0, g);
    chk("wd_next_grant", g, 2'd2);
    txn(4'b1111, 0, 2, TO, 8'h66, 0, 1'b0, g);
    txn(4'b1111, 0, TO - 1, TO - 1, 8'h77, 0, 1'b0, g);
    txn(4'b1111, 0, TO, 0, 8'h88, 0, 1'b0, g);

    // Converter busy in IDLE holds off the start.
    txn(4'b0010, 4, 2, 2, 8'h99, 1, 1'b0, g);
    chk("busy_conv_grant", g, 2'd1);

    for (int i = 0; i < 40; i++) begin
      txn(4'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(0, TO + 1),
          $urandom_range(0, TO + 1), 8'($urandom), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
